// File: rtl/timer_bus_sequencer_if.sv
// Avalon-MM slave-side bus of the interval timer as seen by the hardware sequencer.
// Every access is a single cycle; readdata is valid one cycle after the read address.
interface timer_bus_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/timer_bus_sequencer.sv
// Hardware sequencer for the interval timer: programs period/control, services timeout IRQs,
// counts ticks and reads counter snapshots, exposing a tick/done interface to fabric logic.
module timer_bus_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic [15:0] cfg_count,
    input  logic        abort,
    input  logic        snap_req,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        done,
    output logic        aborted,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    timer_bus_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STS, STOP, CLR_END,
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } access_t;

    localparam access_t NOP = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic access_t wr(input logic [2:0] a, input logic [15:0] d);
        return '{cs: 1'b1, wn: 1'b0, addr: a, wdata: d};
    endfunction

    function automatic access_t rd(input logic [2:0] a);
        return '{cs: 1'b1, wn: 1'b1, addr: a, wdata: 16'd0};
    endfunction

    state_t      state;
    access_t     acc;
    logic [15:0] period_hi;
    logic        cont_q;
    logic [15:0] count_q;
    logic [15:0] snap_lo;
    logic [31:0] snap_q;
    logic [15:0] ctrl_run;
    logic [15:0] next_count;
    logic        abort_hit;

    // Control word {STOP=0, START=1, CONT, ITO=1}
    assign ctrl_run   = {13'd0, 1'b1, cont_q, 1'b1};
    assign next_count = tick_count + 16'd1;
    assign abort_hit  = abort && !(state inside {IDLE, STOP, CLR_END});

    assign bus.chipselect = acc.cs;
    assign bus.write_n    = acc.wn;
    assign bus.address    = acc.addr;
    assign bus.writedata  = acc.wdata;

    // The high half only appears on readdata during SNAP_CAP, so it is forwarded directly.
    assign snap_valid = (state == SNAP_CAP);
    assign snap_value = snap_valid ? {bus.readdata, snap_lo} : snap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= NOP;
            period_hi  <= '0;
            cont_q     <= 1'b0;
            count_q    <= '0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            snap_lo    <= '0;
            snap_q     <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            acc  <= NOP;
            case (state)
                IDLE: if (cfg_start) begin
                    period_hi  <= cfg_period[31:16];
                    cont_q     <= cfg_continuous;
                    count_q    <= cfg_count;
                    tick_count <= '0;
                    aborted    <= 1'b0;
                    busy       <= 1'b1;
                    state      <= WR_PL;
                    acc        <= wr(3'd2, cfg_period[15:0]);
                end
                WR_PL: begin
                    state <= WR_PH;
                    acc   <= wr(3'd3, period_hi);
                end
                WR_PH: begin
                    state <= WR_CTRL;
                    acc   <= wr(3'd1, ctrl_run);
                end
                WR_CTRL: state <= WAIT_IRQ;
                WAIT_IRQ: begin
                    if (bus.irq) begin
                        state <= CLR_STS;
                        tick  <= 1'b1;
                        acc   <= wr(3'd0, 16'd0);
                    end else if (snap_req) begin
                        state <= SNAP_WR;
                        acc   <= wr(3'd4, 16'd0);
                    end
                end
                CLR_STS: begin
                    tick_count <= next_count;
                    if (count_q != 16'd0 && next_count == count_q) begin
                        state <= STOP;
                        acc   <= wr(3'd1, 16'h0008);
                    end else if (!cont_q) begin
                        state <= WR_CTRL;
                        acc   <= wr(3'd1, ctrl_run);
                    end else begin
                        state <= WAIT_IRQ;
                    end
                end
                STOP: begin
                    state <= CLR_END;
                    acc   <= wr(3'd0, 16'd0);
                end
                CLR_END: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                SNAP_WR: begin
                    state <= SNAP_RL;
                    acc   <= rd(3'd4);
                end
                SNAP_RL: begin
                    state <= SNAP_RH;
                    acc   <= rd(3'd5);
                end
                SNAP_RH: begin
                    snap_lo <= bus.readdata;
                    state   <= SNAP_CAP;
                end
                SNAP_CAP: begin
                    snap_q <= {bus.readdata, snap_lo};
                    state  <= WAIT_IRQ;
                end
                default: state <= IDLE;
            endcase
            // Abort overrides whatever the case chose; a coincident irq is dropped without a tick.
            if (abort_hit) begin
                state   <= STOP;
                acc     <= wr(3'd1, 16'h0008);
                aborted <= 1'b1;
                tick    <= 1'b0;
            end
        end
    end
endmodule
